// File: rtl/ft232h_sync_fifo_ctrl.sv
// FT232H FT245-synchronous FIFO controller: arbitrates ADBUS between host->FPGA
// reads and FPGA->host writes, runs bus turnaround and bounds bursts.
module ft232h_sync_fifo_ctrl #(
  parameter int unsigned MAX_BURST     = 64,
  parameter int unsigned RX_SKID_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rxf_n,
  input  logic       i_txe_n,
  output logic       o_rd_n,
  output logic       o_wr_n,
  output logic       o_siwu_n,
  output logic       o_oe_n,
  input  logic [7:0] i_adbus,
  output logic [7:0] o_adbus,
  output logic       o_adbus_oe,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready
);

  localparam int unsigned CW  = $clog2(MAX_BURST + 1);
  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned AW  = $clog2(RX_SKID_DEPTH);
  localparam int unsigned SW  = AW + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RX_OE  = 3'd1,
    RX_RD  = 3'd2,
    RX_END = 3'd3,
    TX_WR  = 3'd4,
    TURN   = 3'd5
  } state_t;

  state_t         state;
  logic [CW-1:0]  burst_cnt;
  logic [CW1-1:0] burst_nxt;
  logic [CW-1:0]  burst_sat;
  logic           burst_hit;
  logic           prio_rx;
  logic           served_rx;

  logic [7:0]     skid_mem [RX_SKID_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [SW-1:0]  skid_cnt;
  logic [SW-1:0]  skid_free;

  logic           rx_pend;
  logic           tx_pend;
  logic           push;
  logic           pop;
  logic           tx_active;
  logic           tx_xfer;

  // Pending qualifiers, skid handshakes and saturating burst count
  always_comb begin
    skid_free = SW'(RX_SKID_DEPTH) - skid_cnt;
    rx_pend   = !i_rxf_n && (skid_free >= SW'(2));
    tx_pend   = !i_txe_n && i_tx_valid;
    push      = !o_rd_n && !i_rxf_n;
    pop       = o_rx_valid && i_rx_ready;
    tx_active = (state == TX_WR);
    tx_xfer   = tx_active && tx_pend;
    burst_nxt = {1'b0, burst_cnt} + CW1'(push || tx_xfer);
    burst_hit = (burst_nxt >= CW1'(MAX_BURST));
    burst_sat = burst_hit ? CW'(MAX_BURST) : burst_nxt[CW-1:0];
  end

  // Write side follows TXE#/valid in the same cycle so a strobed byte is always the accepted one
  always_comb begin
    o_tx_ready = tx_active && !i_txe_n;
    o_wr_n     = !(tx_active && i_tx_valid && !i_txe_n);
    o_adbus    = tx_active ? i_tx_data : 8'h00;
  end

  assign o_siwu_n   = 1'b1;
  assign o_rx_data  = skid_mem[rd_ptr];
  assign o_rx_valid = (skid_cnt != SW'(0));

  // Bus arbitration FSM; strobes and drive enable are registered on each transition
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      o_rd_n     <= 1'b1;
      o_oe_n     <= 1'b1;
      o_adbus_oe <= 1'b0;
      burst_cnt  <= '0;
      prio_rx    <= 1'b1;
      served_rx  <= 1'b0;
    end else begin
      burst_cnt <= burst_sat;
      case (state)
        IDLE: begin
          burst_cnt <= '0;
          if (rx_pend && (prio_rx || !tx_pend)) begin
            state  <= RX_OE;
            o_oe_n <= 1'b0;
          end else if (tx_pend) begin
            state      <= TX_WR;
            o_adbus_oe <= 1'b1;
          end
        end
        RX_OE: begin
          state     <= RX_RD;
          o_rd_n    <= 1'b0;
          burst_cnt <= '0;
        end
        RX_RD: begin
          // RD# deasserts a cycle late, so leave while at least one slot remains
          if (i_rxf_n || (skid_free < SW'(2)) || (burst_hit && tx_pend)) begin
            state     <= RX_END;
            o_rd_n    <= 1'b1;
            served_rx <= 1'b1;
          end
        end
        RX_END: begin
          state  <= TURN;
          o_oe_n <= 1'b1;
        end
        TX_WR: begin
          if (!tx_pend || (burst_hit && rx_pend)) begin
            state      <= TURN;
            o_adbus_oe <= 1'b0;
            served_rx  <= 1'b0;
          end
        end
        TURN: begin
          state   <= IDLE;
          prio_rx <= !served_rx;
        end
        default: begin
          state      <= IDLE;
          o_rd_n     <= 1'b1;
          o_oe_n     <= 1'b1;
          o_adbus_oe <= 1'b0;
        end
      endcase
    end
  end

  // Skid pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      skid_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      skid_cnt <= skid_cnt + SW'(push) - SW'(pop);
    end
  end

  // Skid storage
  always_ff @(posedge clk) begin
    if (push) skid_mem[wr_ptr] <= i_adbus;
  end

endmodule

// File: tb/tb_ft232h_sync_fifo_ctrl.sv
// Bench for ft232h_sync_fifo_ctrl: FT232H host model, stream scoreboards, bus rules.
module tb_ft232h_sync_fifo_ctrl;

  localparam int unsigned MAX_BURST = 64;
  localparam int unsigned SKID      = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxf_n, txe_n, rd_n, wr_n, siwu_n, oe_n, adbus_oe;
  logic       rx_valid, rx_ready, tx_valid, tx_ready;
  logic [7:0] adbus_in, adbus_out, rx_data, tx_data;

  always #5 clk = ~clk;

  ft232h_sync_fifo_ctrl #(.MAX_BURST(MAX_BURST), .RX_SKID_DEPTH(SKID)) dut (
    .clk(clk), .reset(reset),
    .i_rxf_n(rxf_n), .i_txe_n(txe_n),
    .o_rd_n(rd_n), .o_wr_n(wr_n), .o_siwu_n(siwu_n), .o_oe_n(oe_n),
    .i_adbus(adbus_in), .o_adbus(adbus_out), .o_adbus_oe(adbus_oe),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid), .i_rx_ready(rx_ready),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // host holds host_q; rx_exp is the byte stream the consumer must see
  logic [7:0] host_q[$];
  logic [7:0] rx_exp[$];
  // user source tx_src; tx_exp is the byte stream the host must see
  logic [7:0] tx_src[$];
  logic [7:0] tx_exp[$];

  int cyc = 0, rx_seen = 0, tx_seen = 0, rx_got = 0;
  int first_rd = -1, first_val = -1, tx_first = -1, tx_last = -1;
  int run_dir = 0, run_len = 0;
  int burst_len[$];
  int burst_dir[$];
  int rdy_mode = 1;
  bit chk_en = 0, expect_stall = 0;
  bit txe_hold = 1, txe_rand = 0, val_rand = 0, rxf_rand = 0;
  logic prev_aoe = 1'b0, prev_oe_n = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic add_host(input logic [7:0] b);
    host_q.push_back(b);
    rx_exp.push_back(b);
  endtask

  task automatic add_tx(input logic [7:0] b);
    tx_src.push_back(b);
    tx_exp.push_back(b);
  endtask

  // One clock: drive inputs, observe at negedge, let the edge happen, update models
  task automatic tick();
    logic rx_smp, tx_smp, rx_pop, tx_acc;
    logic clash, gap, rd_bad, wr_bad, siwu_bad;
    logic [7:0] e;
    int cur;
    rx_ready = (rdy_mode == 2) ? ($urandom_range(0, 2) != 0) : (rdy_mode == 1);
    rxf_n    = (host_q.size() == 0) || (rxf_rand && ($urandom_range(0, 5) == 0));
    adbus_in = (host_q.size() != 0) ? host_q[0] : 8'h00;
    txe_n    = txe_hold || (txe_rand && ($urandom_range(0, 4) == 0));
    tx_valid = (tx_src.size() != 0) && !(val_rand && ($urandom_range(0, 3) == 0));
    tx_data  = (tx_src.size() != 0) ? tx_src[0] : 8'h00;

    @(negedge clk);
    rx_smp = !rd_n && !rxf_n;
    tx_smp = !wr_n && !txe_n;
    rx_pop = rx_valid && rx_ready;
    tx_acc = tx_valid && tx_ready;
    if (chk_en && !reset) begin
      clash    = adbus_oe && !oe_n;
      gap      = (prev_aoe && !oe_n) || (!prev_oe_n && adbus_oe);
      rd_bad   = !rd_n && (oe_n || prev_oe_n);
      wr_bad   = !wr_n && !adbus_oe;
      siwu_bad = !siwu_n;
      check("bus_rules", 32'({siwu_bad, wr_bad, rd_bad, gap, clash}), 32'(0));
      check("tx_handshake", 32'(tx_acc), 32'(tx_smp));
      if (expect_stall) check("stall_ready_wr", 32'({tx_ready, wr_n}), 32'(2'b01));
      if (!rd_n && first_rd < 0) first_rd = cyc;
      if (rx_valid && first_val < 0) first_val = cyc;
      if (rx_pop) begin
        rx_got++;
        if (rx_exp.size() != 0) begin
          e = rx_exp.pop_front();
          check("rx_data", 32'(rx_data), 32'(e));
        end else check("rx_unexpected", 32'(rx_exp.size()), 32'(1));
      end
      if (tx_smp) begin
        tx_seen++;
        if (tx_first < 0) tx_first = cyc;
        tx_last = cyc;
        check("tx_bus_vs_data", 32'(adbus_out), 32'(tx_data));
        if (tx_exp.size() != 0) begin
          e = tx_exp.pop_front();
          check("host_rx_byte", 32'(adbus_out), 32'(e));
        end else check("tx_unexpected", 32'(tx_exp.size()), 32'(1));
      end
      if (rx_smp) rx_seen++;
      if (rx_smp || tx_smp) begin
        cur = rx_smp ? 1 : 2;
        if (cur != run_dir) begin
          if (run_dir != 0) begin
            burst_len.push_back(run_len);
            burst_dir.push_back(run_dir);
          end
          run_dir = cur;
          run_len = 0;
        end
        run_len++;
      end
    end
    prev_aoe  = adbus_oe;
    prev_oe_n = oe_n;

    @(posedge clk);
    #1;
    if (rx_smp) void'(host_q.pop_front());
    if (tx_acc) void'(tx_src.pop_front());
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    run_dir = 0;
    run_len = 0;
    burst_len.delete();
    burst_dir.delete();
  endtask

  initial begin
    int start, base, i;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_outputs",
          32'({rd_n, wr_n, oe_n, siwu_n, adbus_oe, rx_valid, tx_ready, adbus_out}),
          32'({1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
    chk_en   = 1;
    txe_hold = 0;

    // 1: ten bytes in order, with start-up latency
    rdy_mode = 1;
    for (int k = 0; k < 10; k++) add_host(8'(k));
    start = cyc; base = rx_got; first_rd = -1; first_val = -1;
    for (i = 0; i < 200 && rx_exp.size() != 0; i++) tick();
    repeat (10) tick();
    check("t1_drained", 32'(rx_exp.size()), 32'(0));
    check("t1_count", 32'(rx_got - base), 32'(10));
    check("t1_rd_latency", 32'(first_rd - start), 32'(2));
    check("t1_valid_latency", 32'(first_val - first_rd), 32'(1));

    // 2: consumer stalled, skid fills and RD# stops
    rdy_mode = 0;
    for (int k = 0; k < 8; k++) add_host(8'(8'h40 + k));
    base = rx_seen;
    repeat (30) tick();
    check("t2_sampled_while_stalled", 32'(rx_seen - base), 32'(SKID));
    check("t2_rd_n_high", 32'(rd_n), 32'(1));
    check("t2_rx_valid", 32'(rx_valid), 32'(1));
    rdy_mode = 1; base = rx_got;
    for (i = 0; i < 300 && rx_exp.size() != 0; i++) tick();
    check("t2_drained", 32'(rx_exp.size()), 32'(0));
    check("t2_count", 32'(rx_got - base), 32'(8));

    // 3: 200-byte TX stream without gaps
    for (int k = 0; k < 200; k++) add_tx(8'(8'hA5 + k));
    base = tx_seen; tx_first = -1;
    for (i = 0; i < 1000 && tx_exp.size() != 0; i++) tick();
    repeat (5) tick();
    check("t3_drained", 32'(tx_exp.size()), 32'(0));
    check("t3_count", 32'(tx_seen - base), 32'(200));
    check("t3_no_gap", 32'(tx_last - tx_first + 1), 32'(200));

    // 4: both sides pending, bursts alternate at MAX_BURST
    do_reset();
    for (int k = 0; k < 400; k++) begin
      add_host(8'($urandom));
      add_tx(8'($urandom));
    end
    repeat (700) tick();
    check("t4_enough_bursts", 32'(burst_len.size() >= 4), 32'(1));
    if (burst_dir.size() != 0) check("t4_first_is_rx", 32'(burst_dir[0]), 32'(1));
    foreach (burst_len[k]) check("t4_burst_len", 32'(burst_len[k]), MAX_BURST);
    for (i = 0; i < 3000 && (rx_exp.size() != 0 || tx_exp.size() != 0); i++) tick();
    check("t4_rx_drained", 32'(rx_exp.size()), 32'(0));
    check("t4_tx_drained", 32'(tx_exp.size()), 32'(0));

    // 5: TXE# rises after 17 bytes; byte 17 must follow once TXE# returns
    for (int k = 0; k < 40; k++) add_tx(8'($urandom));
    base = tx_seen;
    for (i = 0; i < 200 && (tx_seen - base) < 17; i++) tick();
    check("t5_reached_17", 32'(tx_seen - base), 32'(17));
    txe_hold = 1; expect_stall = 1;
    tick();
    expect_stall = 0; txe_hold = 0;
    for (i = 0; i < 300 && tx_exp.size() != 0; i++) tick();
    check("t5_drained", 32'(tx_exp.size()), 32'(0));
    check("t5_count", 32'(tx_seen - base), 32'(40));

    // 6: reset during a read burst
    for (int k = 0; k < 30; k++) add_host(8'($urandom));
    for (i = 0; i < 50 && rd_n !== 1'b0; i++) tick();
    check("t6_in_read", 32'(rd_n), 32'(0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_after_reset",
          32'({rd_n, wr_n, oe_n, adbus_oe, rx_valid, tx_ready}),
          32'(6'b111000));
    rx_exp = host_q;
    run_dir = 0;
    for (i = 0; i < 300 && rx_exp.size() != 0; i++) tick();
    check("t6_drained", 32'(rx_exp.size()), 32'(0));

    // random traffic on both sides with stalls
    rdy_mode = 2; txe_rand = 1; val_rand = 1; rxf_rand = 1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 2) == 0) add_host(8'($urandom));
      if ($urandom_range(0, 2) == 0) add_tx(8'($urandom));
      tick();
    end
    rdy_mode = 1; txe_rand = 0; val_rand = 0; rxf_rand = 0;
    for (i = 0; i < 5000 && (rx_exp.size() != 0 || tx_exp.size() != 0); i++) tick();
    check("rand_rx_drained", 32'(rx_exp.size()), 32'(0));
    check("rand_tx_drained", 32'(tx_exp.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
